// File: rtl/conv_tile_loader_if.sv
// Handshake and data bundle between the convolution tile loader and its neighbours.
// The master side drives kernel/pixel inputs and tile_ready; the slave side is the loader.
interface conv_tile_loader_if;
   logic       wt_valid;
   logic [7:0] wt_data;
   logic [7:0] weight_tile [0:3];
   logic       wt_loaded;
   logic       pix_valid;
   logic [7:0] pix_data;
   logic       pix_ready;
   logic       tile_valid;
   logic       tile_ready;
   logic [7:0] activation_tile [0:8];
   logic       tile_last;

   modport master (
      output wt_valid, wt_data, pix_valid, pix_data, tile_ready,
      input  weight_tile, wt_loaded, pix_ready, tile_valid, activation_tile, tile_last
   );

   modport slave (
      input  wt_valid, wt_data, pix_valid, pix_data, tile_ready,
      output weight_tile, wt_loaded, pix_ready, tile_valid, activation_tile, tile_last
   );
endinterface

// File: rtl/conv_tile_loader.sv
// Raster pixel stream to stride-2 overlapping 3x3 activation tiles, with a 4-byte kernel
// register, two line buffers and a single output tile register under valid/ready backpressure.
module conv_tile_loader #(
   parameter int IMG_W = 9,
   parameter int IMG_H = 9
) (
   input  logic                 clk,
   input  logic                 reset,
   conv_tile_loader_if.slave    bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [1:0]    wt_idx;
   logic          wt_loaded_q;
   logic [7:0]    wt_q [0:3];
   logic          tile_valid_q;
   logic          tile_last_q;
   logic [7:0]    act_q [0:8];

   logic [7:0]    lb1 [0:IMG_W-1];
   logic [7:0]    lb2 [0:IMG_W-1];
   logic [7:0]    win0 [0:1];
   logic [7:0]    win1 [0:1];
   logic [7:0]    win2 [0:1];

   logic          pix_ready;
   logic          accept;
   logic          complete;
   logic [7:0]    up1;
   logic [7:0]    up2;
   logic [7:0]    tile_next [0:8];

   assign pix_ready = wt_loaded_q && (!tile_valid_q || bus.tile_ready);
   assign accept    = bus.pix_valid && pix_ready;
   assign complete  = accept && (row >= RW'(2)) && !row[0] && (col >= CW'(2)) && !col[0];

   always_comb begin
      up1 = lb1[col];
      up2 = lb2[col];
      // Two registered columns per row plus the values arriving this cycle form the 3x3 window
      tile_next[0] = win0[0];
      tile_next[1] = win0[1];
      tile_next[2] = up2;
      tile_next[3] = win1[0];
      tile_next[4] = win1[1];
      tile_next[5] = up1;
      tile_next[6] = win2[0];
      tile_next[7] = win2[1];
      tile_next[8] = bus.pix_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wt_idx      <= '0;
         wt_loaded_q <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) wt_q[i] <= '0;
      end else if (bus.wt_valid) begin
         wt_q[wt_idx] <= bus.wt_data;
         wt_idx       <= wt_idx + 2'd1;
         if (wt_idx == 2'd3) wt_loaded_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Pixel storage is data-only and deliberately left out of reset
   always_ff @(posedge clk) begin
      if (accept) begin
         lb2[col] <= up1;
         lb1[col] <= bus.pix_data;
         win0[0]  <= win0[1];
         win0[1]  <= up2;
         win1[0]  <= win1[1];
         win1[1]  <= up1;
         win2[0]  <= win2[1];
         win2[1]  <= bus.pix_data;
      end
   end

   // A completing pixel replaces a tile being accepted on the same edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tile_valid_q <= 1'b0;
         tile_last_q  <= 1'b0;
         for (int unsigned i = 0; i < 9; i++) act_q[i] <= '0;
      end else if (complete) begin
         tile_valid_q <= 1'b1;
         tile_last_q  <= (row == ROW_LAST) && (col == COL_LAST);
         for (int unsigned i = 0; i < 9; i++) act_q[i] <= tile_next[i];
      end else if (bus.tile_ready) begin
         tile_valid_q <= 1'b0;
         tile_last_q  <= 1'b0;
      end
   end

   assign bus.weight_tile     = wt_q;
   assign bus.wt_loaded       = wt_loaded_q;
   assign bus.pix_ready       = pix_ready;
   assign bus.tile_valid      = tile_valid_q;
   assign bus.activation_tile = act_q;
   assign bus.tile_last       = tile_last_q;
endmodule

// File: tb/tb_conv_tile_loader.sv
// Directed bench for conv_tile_loader: a 5x5 instance for kernel gating, tile content,
// backpressure, frame wrap and reset, plus a default 9x9 instance for the full-size frame.
module tb_conv_tile_loader;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   acc5     = 0;
   int   acc9     = 0;

   logic [71:0] q5 [$];
   logic        l5 [$];
   logic [71:0] q9 [$];
   logic        l9 [$];
   logic [71:0] exp5 [0:3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   conv_tile_loader_if b5 ();
   conv_tile_loader_if b9 ();

   conv_tile_loader #(.IMG_W(5), .IMG_H(5)) dut5 (.clk(clk), .reset(reset), .bus(b5.slave));
   conv_tile_loader #(.IMG_W(9), .IMG_H(9)) dut9 (.clk(clk), .reset(reset), .bus(b9.slave));

   function automatic logic [71:0] pack_t(input logic [7:0] a [0:8]);
      logic [71:0] p = '0;
      for (int i = 0; i < 9; i++) p = {p[63:0], a[i]};
      return p;
   endfunction

   function automatic logic [31:0] pack_w(input logic [7:0] a [0:3]);
      return {a[0], a[1], a[2], a[3]};
   endfunction

   task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Tiles leave the register when valid && ready at the upcoming edge
   always @(negedge clk) begin
      if (b5.pix_valid && b5.pix_ready) acc5++;
      if (b9.pix_valid && b9.pix_ready) acc9++;
      if (b5.tile_valid && b5.tile_ready) begin
         q5.push_back(pack_t(b5.activation_tile));
         l5.push_back(b5.tile_last);
      end
      if (b9.tile_valid && b9.tile_ready) begin
         q9.push_back(pack_t(b9.activation_tile));
         l9.push_back(b9.tile_last);
      end
   end

   task automatic send5(input logic [7:0] v);
      logic ok = 1'b0;
      b5.pix_valid = 1'b1;
      b5.pix_data  = v;
      for (int g = 0; g < 100 && !ok; g++) begin
         @(negedge clk);
         ok = b5.pix_ready;
         @(posedge clk);
         #1;
      end
      b5.pix_valid = 1'b0;
      if (!ok) check_eq("send5_accept_timeout", {71'b0, ok}, 72'd1);
   endtask

   task automatic send9(input logic [7:0] v);
      logic ok = 1'b0;
      b9.pix_valid = 1'b1;
      b9.pix_data  = v;
      for (int g = 0; g < 100 && !ok; g++) begin
         @(negedge clk);
         ok = b9.pix_ready;
         @(posedge clk);
         #1;
      end
      b9.pix_valid = 1'b0;
      if (!ok) check_eq("send9_accept_timeout", {71'b0, ok}, 72'd1);
   endtask

   task automatic load_w5();
      logic [7:0] k [0:3] = '{8'd3, 8'd1, 8'd4, 8'd1};
      for (int i = 0; i < 4; i++) begin
         b5.wt_valid = 1'b1;
         b5.wt_data  = k[i];
         @(posedge clk);
         #1;
         if (i == 2) check_eq("wt_loaded_after_3", b5.wt_loaded, 1'b0);
      end
      b5.wt_valid = 1'b0;
      check_eq("weight_tile", pack_w(b5.weight_tile), 32'h03010401);
      check_eq("wt_loaded", b5.wt_loaded, 1'b1);
      check_eq("pix_ready_after_load", b5.pix_ready, 1'b1);
   endtask

   task automatic check_frame5(input string tag);
      check_eq({tag, "_count"}, q5.size(), 4);
      for (int i = 0; i < 4 && i < q5.size(); i++) begin
         check_eq($sformatf("%s_tile%0d", tag, i), q5[i], exp5[i]);
         check_eq($sformatf("%s_last%0d", tag, i), l5[i], (i == 3));
      end
      q5.delete();
      l5.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int a0;
      exp5[0] = 72'h00_01_02_05_06_07_0a_0b_0c;
      exp5[1] = 72'h02_03_04_07_08_09_0c_0d_0e;
      exp5[2] = 72'h0a_0b_0c_0f_10_11_14_15_16;
      exp5[3] = 72'h0c_0d_0e_11_12_13_16_17_18;

      reset = 1'b0;
      b5.wt_valid = 1'b0; b5.wt_data = '0; b5.pix_valid = 1'b0; b5.pix_data = '0; b5.tile_ready = 1'b1;
      b9.wt_valid = 1'b0; b9.wt_data = '0; b9.pix_valid = 1'b0; b9.pix_data = '0; b9.tile_ready = 1'b1;
      #12;
      check_eq("rst_pix_ready", b5.pix_ready, 1'b0);
      check_eq("rst_wt_loaded", b5.wt_loaded, 1'b0);
      check_eq("rst_tile_valid", b5.tile_valid, 1'b0);
      check_eq("rst_weights", pack_w(b5.weight_tile), 32'h0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;

      // Kernel gating
      b5.pix_valid = 1'b1;
      b5.pix_data  = 8'd55;
      repeat (3) @(posedge clk);
      #1;
      check_eq("gate_pix_ready", b5.pix_ready, 1'b0);
      check_eq("gate_no_accept", acc5, 0);
      b5.pix_valid = 1'b0;
      load_w5();

      // Tile content, latency and throughput
      t0 = cyc;
      for (int v = 0; v < 12; v++) send5(8'(v));
      check_eq("pre_tile_valid", b5.tile_valid, 1'b0);
      send5(8'd12);
      check_eq("first_tile_valid", b5.tile_valid, 1'b1);
      check_eq("first_tile_data", pack_t(b5.activation_tile), exp5[0]);
      for (int v = 13; v < 25; v++) send5(8'(v));
      check_eq("frame_cycles", cyc - t0, 25);
      repeat (3) @(posedge clk);
      #1;
      check_frame5("content");

      // Backpressure
      for (int v = 0; v < 13; v++) send5(8'(v));
      b5.tile_ready = 1'b0;
      a0 = acc5;
      b5.pix_valid = 1'b1;
      b5.pix_data  = 8'd13;
      repeat (4) @(posedge clk);
      #1;
      check_eq("stall_pix_ready", b5.pix_ready, 1'b0);
      check_eq("stall_tile_valid", b5.tile_valid, 1'b1);
      check_eq("stall_tile_data", pack_t(b5.activation_tile), exp5[0]);
      check_eq("stall_tile_last", b5.tile_last, 1'b0);
      check_eq("stall_no_accept", acc5 - a0, 0);
      b5.tile_ready = 1'b1;
      for (int v = 13; v < 25; v++) send5(8'(v));
      repeat (3) @(posedge clk);
      #1;
      check_frame5("bp");

      // Back-to-back frames
      for (int v = 0; v < 25; v++) send5(8'(v));
      for (int v = 100; v < 125; v++) send5(8'(v));
      repeat (3) @(posedge clk);
      #1;
      check_eq("b2b_count", q5.size(), 8);
      if (q5.size() == 8) begin
         check_eq("b2b_tile4_hand", q5[4], 72'h64_65_66_69_6a_6b_6e_6f_70);
         for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("b2b_tile%0d", i), q5[i],
                     exp5[i % 4] + ((i >= 4) ? {9{8'd100}} : 72'h0));
            check_eq($sformatf("b2b_last%0d", i), l5[i], (i % 4 == 3));
         end
      end
      q5.delete();
      l5.delete();

      // Asynchronous reset mid-frame
      for (int v = 0; v < 18; v++) send5(8'(v));
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_eq("mid_rst_pix_ready", b5.pix_ready, 1'b0);
      check_eq("mid_rst_wt_loaded", b5.wt_loaded, 1'b0);
      check_eq("mid_rst_tile_valid", b5.tile_valid, 1'b0);
      check_eq("mid_rst_tile_last", b5.tile_last, 1'b0);
      check_eq("mid_rst_weights", pack_w(b5.weight_tile), 32'h0);
      check_eq("mid_rst_act", pack_t(b5.activation_tile), 72'h0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      q5.delete();
      l5.delete();
      load_w5();
      for (int v = 0; v < 25; v++) send5(8'(v));
      repeat (3) @(posedge clk);
      #1;
      check_frame5("after_rst");

      // Default 9x9 frame
      for (int i = 0; i < 4; i++) begin
         b9.wt_valid = 1'b1;
         b9.wt_data  = 8'(i + 1);
         @(posedge clk);
         #1;
      end
      b9.wt_valid = 1'b0;
      check_eq("w9_loaded", b9.wt_loaded, 1'b1);
      for (int v = 0; v < 81; v++) send9(8'(v));
      repeat (3) @(posedge clk);
      #1;
      check_eq("f9_count", q9.size(), 16);
      if (q9.size() == 16) begin
         int nl = 0;
         check_eq("f9_tile0", q9[0], 72'h00_01_02_09_0a_0b_12_13_14);
         check_eq("f9_tile15", q9[15], 72'h3c_3d_3e_45_46_47_4e_4f_50);
         check_eq("f9_last15", l9[15], 1'b1);
         foreach (l9[i]) if (l9[i]) nl++;
         check_eq("f9_last_count", nl, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/conv_tile_loader.md
# conv_tile_loader

Upstream feeder for the 2x2-kernel systolic convolution array. Accepts a raster-order 8-bit pixel stream of one IMG_W x IMG_H frame and a 4-byte kernel. Emits stride-2, overlapping 3x3 activation tiles in the array's 9-entry row-major order, plus the registered kernel. Uses two line buffers and a one-entry output register with valid/ready backpressure.

## Interface
- IMG_W, default 9: frame width in pixels. Must be odd and at least 3.
- IMG_H, default 9: frame height in pixels. Must be odd and at least 3.
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wt_valid  in  1  kernel byte strobe.
- wt_data  in  8  kernel byte; order k00, k01, k10, k11.
- weight_tile[0:3]  out  8 each  registered kernel, index = load order.
- wt_loaded  out  1  high once 4 kernel bytes have been written.
- pix_valid  in  1  pixel present.
- pix_data  in  8  pixel, raster order: row 0 col 0 first.
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready.
- tile_valid  out  1  tile register holds a tile.
- tile_ready  in  1  downstream accepts the tile when tile_valid && tile_ready.
- activation_tile[0:8]  out  8 each  entry 3*i+j = pixel(r-2+i, c-2+j).
- tile_last  out  1  qualifies the final tile of the frame.

## Operation
**Kernel load**
- Each wt_valid cycle writes wt_data to weight_tile[wt_idx], then wt_idx increments mod 4.
- wt_loaded sets on the 4th write and stays set until reset.
- Writes after wt_loaded wrap from index 0. They overwrite live weights and are legal only between frames; this is not checked.

**Pixel acceptance**
- pix_ready = wt_loaded && (!tile_valid || tile_ready). This is combinational from tile_ready.
- Pixels are never accepted before the kernel is loaded.

**Counters and storage**
- col counts 0..IMG_W-1 and row counts 0..IMG_H-1, advancing on each accepted pixel.
- col wraps to 0 and row increments. At (IMG_H-1, IMG_W-1) both wrap to 0, and the next frame starts with no gap.
- Line buffers hold rows r-1 and r-2 (2*IMG_W bytes, contents not reset).
- A 3-column shift window per buffered row, plus the current row, holds the last 3 columns.

**Tile emission**
- A tile completes on accepting pixel (r, c) with r >= 2 even and c >= 2 even.
- On completion, activation_tile is loaded and tile_valid sets on the same edge.
- tile_last = 1 iff (r, c) = (IMG_H-1, IMG_W-1).
- Tiles per frame = ((IMG_W-1)/2) * ((IMG_H-1)/2), emitted in raster order of (r, c).
- tile_valid clears on the accept edge unless a new tile completes on that same edge, in which case the new tile replaces it (simultaneous accept + complete).
- activation_tile and tile_last hold stable while tile_valid && !tile_ready.

**Reset**
- Asynchronous, active-low; takes effect mid-frame or mid-kernel-load.
- Clears row, col, wt_idx, wt_loaded, tile_valid and tile_last.
- Clears weight_tile and activation_tile to 0.
- Any partial frame is discarded; after reset, the first accepted pixel is treated as (0, 0).

## Timing
- Tile latency: tile_valid is high in the cycle after the completing pixel is accepted (1 cycle).
- Throughput: 1 pixel per cycle when tile_ready is held high. No bubbles at row or frame wrap.
- Kernel: weight_tile[k] updates 1 cycle after its write; wt_loaded is high 1 cycle after the 4th write.
- Stall: with tile_valid high and tile_ready low, pix_ready is low, and row, col and the line buffers are frozen.
- Reset values of all outputs are 0, including pix_ready.

## Test plan
- **Kernel gating:** IMG_W=IMG_H=5; hold pix_valid with no kernel -> pix_ready=0 and no acceptance. Write 3, 1, 4, 1 -> weight_tile = {3,1,4,1}; wt_loaded=1 and pix_ready=1 the next cycle.
- **Tile content:** stream pixels 0..24 with tile_ready=1 -> exactly 4 tiles, in order:
  - {0,1,2,5,6,7,10,11,12}, one cycle after pixel 12;
  - {2,3,4,7,8,9,12,13,14};
  - {10,11,12,15,16,17,20,21,22};
  - {12,13,14,17,18,19,22,23,24} with tile_last=1.
- **Backpressure:** hold tile_ready=0 after the first tile -> pix_ready=0, tile stays {0,1,2,5,6,7,10,11,12}, no pixel is lost. Release -> remaining tiles match the previous scenario.
- **Back-to-back frames:** stream pixels 0..24, then 100..124 contiguously -> the 5th tile is {100,101,102,105,106,107,110,111,112}, and tile_last pulses on the 4th and 8th tiles only.
- **Reset mid-frame:** assert reset after pixel 17 -> all outputs 0 and wt_loaded=0. Reload the kernel and stream 0..24 -> same 4 tiles as the tile-content scenario.
- **Default size:** IMG_W=IMG_H=9, pixels 0..80 -> 16 tiles; tile 16 is {60,61,62,69,70,71,78,79,80} with tile_last=1.
